remote_comm: RTL and testbench
==============================

REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, the uart sub-module clocks per bit (19200 baud at 50 MHz).
REQ-002 SHALL have parameter TMO_CYCLES, default 2**20, the clocks allowed in WAIT_RESP before a timeout (used only with RESP_TMO_EN).
REQ-003 SHALL have port clk, input, 1: the single system clock; all flops are on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port snd_cmd, input, 1: one-cycle request to transmit a command.
REQ-006 SHALL have port cmd, input, 8: opcode, sampled with snd_cmd.
REQ-007 SHALL have port data, input, 16: payload, sampled with snd_cmd.
REQ-008 SHALL have port TX, output, 1: UART serial out, idle high.
REQ-009 SHALL have port RX, input, 1: UART serial in.
REQ-010 SHALL have port cmd_cmplt, output, 1: one-cycle pulse when the final byte finishes transmitting.
REQ-011 SHALL have port resp_rdy, output, 1: one-cycle pulse when resp is valid.
REQ-012 SHALL have port resp, output, 8: last response byte received.
REQ-013 SHALL have port resp_tmo, output, 1: one-cycle pulse on response timeout.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, TX_CMD, TX_DHI, TX_DLO, WAIT_RESP.
REQ-016 In IDLE, snd_cmd SHALL latch {cmd,data} into a 24-bit shadow register and move to TX_CMD on the next edge.
REQ-017 snd_cmd SHALL be ignored (not queued) while busy=1.
REQ-018 Byte order SHALL be cmd, then data[15:8], then data[7:0]: exactly three UART frames per command.
REQ-019 trmt to the uart SHALL pulse for exactly one cycle on entry to each TX_* state; the state SHALL advance only on the uart tx_done.
REQ-020 On tx_done in TX_DLO, cmd_cmplt SHALL pulse on the same edge that enters WAIT_RESP.
REQ-021 In WAIT_RESP, a uart rx_rdy SHALL load resp, pulse resp_rdy and clr_rx_rdy for one cycle, and return to IDLE.
REQ-022 A received byte while in IDLE or TX_* SHALL be discarded via clr_rx_rdy; resp is unchanged.
REQ-023 resp SHALL hold its value until the next valid response or timeout.
REQ-024 snd_cmd may arrive on the same cycle resp_rdy returns to IDLE-next; it SHALL be accepted on the first cycle state==IDLE.
REQ-025 Shadow register contents SHALL NOT change while busy=1, even if cmd or data change.

Reset
REQ-026 On rst_n low, the block SHALL go to IDLE asynchronously, with resp=8'h00, busy, cmd_cmplt, resp_rdy, resp_tmo and trmt all 0, shadow=0, timeout counter=0, and TX high.
REQ-027 Reset mid-frame SHALL abort the command; no cmd_cmplt or resp_rdy pulse follows.

Configuration
REQ-028 When macro RESP_TMO_EN is defined, a counter SHALL clear on entry to WAIT_RESP and increment each cycle; on reaching TMO_CYCLES-1 without rx_rdy it SHALL set resp=8'h00, pulse resp_tmo and return to IDLE.
REQ-029 When RESP_TMO_EN is undefined, WAIT_RESP SHALL wait indefinitely, resp_tmo SHALL be tied 0, and no counter SHALL be synthesized.
REQ-030 If rx_rdy and timeout expiry coincide, the response SHALL win.

Structure
REQ-031 Package remote_comm_pkg SHALL hold the state enum, POS_ACK=8'hA5, and opcode constants (SET_PTCH=8'h02, SET_ROLL=8'h03, SET_YAW=8'h04, SET_THRST=8'h05, CALIBRATE=8'h06, EMER_LAND=8'h07, MTRS_OFF=8'h08).
REQ-032 The block SHALL instantiate exactly one sub-module, uart (tx plus rx, parameter BAUD_DIV); the byte sequencing and timeout SHALL live in remote_comm.

Verification
REQ-033 The bench SHALL drive snd_cmd with cmd=8'h02 and data=16'h1234, and SHALL check TX frames 02, 12, 34 in order, one trmt per frame, and cmd_cmplt once after the third stop bit.
REQ-034 The bench SHALL loop TX through a cmd receiver model that returns 8'hA5, and SHALL check resp=8'hA5 with one resp_rdy pulse, then busy=0.
REQ-035 The bench SHALL pulse snd_cmd with cmd=8'h05 while sending 8'h08, and SHALL check that only the 08 frames appear and the 05 is dropped.
REQ-036 With RESP_TMO_EN and TMO_CYCLES=1000, the bench SHALL give no reply, and SHALL check resp_tmo pulses 1000 cycles after WAIT_RESP entry with resp=8'h00 and busy=0.
REQ-037 The bench SHALL assert rst_n low during the second frame, and SHALL check immediate IDLE, TX=1, and no cmd_cmplt; a new snd_cmd with cmd=8'h06 and data=16'h0000 then SHALL complete normally.
REQ-038 The bench SHALL inject byte 8'h55 on RX while in IDLE, then send a command answered with 8'hA5, and SHALL check that resp stays 8'h00 until 8'hA5 arrives.

Source files
------------

// File: rtl/remote_comm_pkg.sv
// Shared constants for the remote command link: FSM state codes, ack byte, opcodes.
// No logic; latency and backpressure are defined by the modules that import this.
// States are plain constants so older tools and logic analysers see fixed codes.
package remote_comm_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t TX_CMD    = 3'd1;
  localparam state_t TX_DHI    = 3'd2;
  localparam state_t TX_DLO    = 3'd3;
  localparam state_t WAIT_RESP = 3'd4;

  localparam logic [7:0] POS_ACK   = 8'hA5;

  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART transmitter and receiver sharing one BAUD_DIV clocks-per-bit setting.
// Latency: tx_done 10*BAUD_DIV cycles after trmt; rx_rdy at stop-bit centre.
// No backpressure: trmt while sending restarts the frame; rx_rdy stays set until clr_rx_rdy.
module remote_comm_uart #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [8:0]    tx_shft;
  logic [3:0]    tx_bits;
  logic [CW-1:0] tx_cnt;
  logic          tx_busy;

  // tx_shft[0] drives the line; ones shift in so the stop bit and idle are high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft <= '1;
      tx_bits <= '0;
      tx_cnt  <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt) begin
        tx_shft <= {tx_data, 1'b0};
        tx_bits <= '0;
        tx_cnt  <= '0;
        tx_busy <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt == CW'(BAUD_DIV - 1)) begin
          tx_cnt <= '0;
          if (tx_bits == 4'd9) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            tx_bits <= tx_bits + 4'd1;
            tx_shft <= {1'b1, tx_shft[8:1]};
          end
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end
    end
  end

  assign TX = tx_shft[0];

  logic [1:0]    rx_sync;
  logic          rx_in;
  logic          rx_busy;
  logic [3:0]    rx_bits;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    rx_shft;

  assign rx_in = rx_sync[1];

  // Counter starts half-way so every sample lands mid-bit; bit 0 is the start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11;
      rx_busy <= 1'b0;
      rx_bits <= '0;
      rx_cnt  <= '0;
      rx_shft <= '0;
      rx_rdy  <= 1'b0;
      rx_data <= '0;
    end else begin
      rx_sync <= {rx_sync[0], RX};
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (!rx_in) begin
          rx_busy <= 1'b1;
          rx_bits <= '0;
          rx_cnt  <= CW'(BAUD_DIV / 2);
        end
      end else if (rx_cnt == CW'(BAUD_DIV - 1)) begin
        rx_cnt <= '0;
        if (rx_bits == 4'd0 && rx_in) begin
          rx_busy <= 1'b0;
        end else if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          rx_rdy  <= 1'b1;
          rx_data <= rx_shft;
        end else begin
          rx_bits <= rx_bits + 4'd1;
          if (rx_bits != 4'd0) rx_shft <= {rx_in, rx_shft[7:1]};
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Sends {cmd, data_hi, data_lo} as three UART frames, then waits for a one-byte reply (RESP_TMO_EN adds a timeout).
// Latency: ~30*BAUD_DIV cycles to cmd_cmplt; resp_rdy one cycle after the reply byte lands.
// snd_cmd is dropped while busy; stray received bytes outside WAIT_RESP are discarded.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV   = 2604,
  parameter int TMO_CYCLES = 2**20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        TX,
  input  logic        RX,
  output logic        cmd_cmplt,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        resp_tmo,
  output logic        busy
);

  state_t      state;
  logic [23:0] shadow;
  logic        trmt;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [7:0]  rx_data;

  remote_comm_uart #(.BAUD_DIV(BAUD_DIV)) uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .trmt       (trmt),
    .tx_data    (tx_byte),
    .tx_done    (tx_done),
    .TX         (TX),
    .RX         (RX),
    .clr_rx_rdy (clr_rx_rdy),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data)
  );

  // Every received byte is consumed immediately: taken as resp in WAIT_RESP, dropped elsewhere
  assign clr_rx_rdy = rx_rdy;
  assign busy       = (state != IDLE);

  always_comb begin
    case (state)
      TX_DHI:  tx_byte = shadow[15:8];
      TX_DLO:  tx_byte = shadow[7:0];
      default: tx_byte = shadow[23:16];
    endcase
  end

`ifdef RESP_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_expired;
  logic             resp_tmo_q;

  assign tmo_expired = (state == WAIT_RESP) && (tmo_cnt == TMO_W'(TMO_CYCLES - 1));

  // Held at zero outside WAIT_RESP, so it is already clear on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt    <= '0;
      resp_tmo_q <= 1'b0;
    end else begin
      resp_tmo_q <= tmo_expired && !rx_rdy;
      if (state != WAIT_RESP) tmo_cnt <= '0;
      else                    tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign resp_tmo = resp_tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYCLES;
  assign resp_tmo   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      trmt      <= 1'b0;
      cmd_cmplt <= 1'b0;
      resp_rdy  <= 1'b0;
      resp      <= 8'h00;
    end else begin
      trmt      <= 1'b0;
      cmd_cmplt <= 1'b0;
      resp_rdy  <= 1'b0;
      case (state)
        IDLE: if (snd_cmd) begin
          shadow <= {cmd, data};
          trmt   <= 1'b1;
          state  <= TX_CMD;
        end
        TX_CMD: if (tx_done) begin
          trmt  <= 1'b1;
          state <= TX_DHI;
        end
        TX_DHI: if (tx_done) begin
          trmt  <= 1'b1;
          state <= TX_DLO;
        end
        TX_DLO: if (tx_done) begin
          cmd_cmplt <= 1'b1;
          state     <= WAIT_RESP;
        end
        WAIT_RESP: begin
          // A reply arriving on the expiry cycle still wins
          if (rx_rdy) begin
            resp     <= rx_data;
            resp_rdy <= 1'b1;
            state    <= IDLE;
          end
`ifdef RESP_TMO_EN
          else if (tmo_expired) begin
            resp  <= 8'h00;
            state <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm: frame decoder, reply driver and a per-cycle scoreboard.
module tb_remote_comm;

  localparam int BD  = 8;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        RX = 1'b1;
  logic        TX, cmd_cmplt, resp_rdy, resp_tmo, busy;
  logic [7:0]  resp;

  remote_comm #(.BAUD_DIV(BD), .TMO_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .snd_cmd   (snd_cmd),
    .cmd       (cmd),
    .data      (data),
    .TX        (TX),
    .RX        (RX),
    .cmd_cmplt (cmd_cmplt),
    .resp_rdy  (resp_rdy),
    .resp      (resp),
    .resp_tmo  (resp_tmo),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: expected frame bytes, queued replies, expected resp/busy
  logic [7:0] exp_frames[$];
  logic [7:0] got_frames[$];
  logic [7:0] reply_q[$];
  logic [7:0] model_resp = 8'h00;
  bit         exp_busy = 1'b0;
  bit         prev_cmplt = 1'b0, prev_rdy = 1'b0;
  int cyc = 0, dec_cnt = 0, dec_base = 0, rst_epoch = 0;
  int cmplt_cnt = 0, rdy_cnt = 0, tmo_cnt = 0, trmt_cnt = 0, cmplt_cyc = 0, tmo_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_busy   = 1'b0;
      model_resp = 8'h00;
      prev_cmplt = 1'b0;
      prev_rdy   = 1'b0;
      exp_frames.delete();
      reply_q.delete();
    end else begin
      if (dut.trmt) trmt_cnt++;
      if (cmd_cmplt) begin
        cmplt_cnt++;
        cmplt_cyc = cyc;
        chk("cmplt_after_third_frame", dec_cnt - dec_base, 3);
      end
      if (resp_rdy) begin
        rdy_cnt++;
        n_cmp++;
        if (reply_q.size() == 0) begin
          n_bad++;
          $display("FAIL resp_rdy_unexpected: got resp %02h with no reply outstanding", resp);
        end else begin
          model_resp = reply_q.pop_front();
        end
      end
      if (resp_tmo) begin
        tmo_cnt++;
        tmo_cyc    = cyc;
        model_resp = 8'h00;
      end
      if (resp_rdy || resp_tmo) exp_busy = 1'b0;
      chk("resp", resp, model_resp);
      chk("busy", busy, exp_busy);
      if (!exp_busy) chk("tx_idle_high", TX, 1);
      chk("single_cycle_pulse", (cmd_cmplt && prev_cmplt) || (resp_rdy && prev_rdy), 0);
      prev_cmplt = cmd_cmplt;
      prev_rdy   = resp_rdy;
      if (!exp_busy && snd_cmd) begin
        exp_busy = 1'b1;
        dec_base = dec_cnt;
        exp_frames.push_back(cmd);
        exp_frames.push_back(data[15:8]);
        exp_frames.push_back(data[7:0]);
      end
    end
  end

  // Serial decoder on TX, sampling at bit centres
  initial begin
    forever begin
      int         ep;
      logic [7:0] b;
      logic       st, sp;
      @(negedge clk);
      if (rst_n && TX === 1'b0) begin
        ep = rst_epoch;
        repeat (BD / 2) @(negedge clk);
        st = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BD) @(negedge clk);
        sp = TX;
        if (ep == rst_epoch) begin
          chk("tx_start_bit", st, 0);
          chk("tx_stop_bit", sp, 1);
          got_frames.push_back(b);
          dec_cnt++;
          n_cmp++;
          if (exp_frames.size() == 0) begin
            n_bad++;
            $display("FAIL tx_frame: got unexpected byte %02h, none expected", b);
          end else if (b !== exp_frames[0]) begin
            n_bad++;
            $display("FAIL tx_frame: got %02h expected %02h", b, exp_frames[0]);
            void'(exp_frames.pop_front());
          end else begin
            void'(exp_frames.pop_front());
          end
        end
      end
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  function automatic int get_cnt(input int which);
    case (which)
      0:       return cmplt_cnt;
      1:       return rdy_cnt;
      2:       return tmo_cnt;
      default: return dec_cnt;
    endcase
  endfunction

  task automatic wait_cnt(input string name, input int which, input int target, input int lim);
    int n = 0;
    while (get_cnt(which) < target && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_wait"}, get_cnt(which) >= target, 1);
  endtask

  task automatic pulse_snd(input logic [7:0] c, input logic [15:0] d);
    @(posedge clk);
    #1;
    cmd     = c;
    data    = d;
    snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    snd_cmd = 1'b0;
  endtask

  task automatic check_frames(input string name, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
    chk({name, "_nframes"}, got_frames.size(), 3);
    if (got_frames.size() == 3) begin
      chk({name, "_frame0"}, got_frames[0], b0);
      chk({name, "_frame1"}, got_frames[1], b1);
      chk({name, "_frame2"}, got_frames[2], b2);
    end
  endtask

  task automatic reply_and_check(input string name, input logic [7:0] r);
    int r0;
    r0 = rdy_cnt;
    reply_q.push_back(r);
    send_rx(r);
    wait_cnt({name, "_resp_rdy"}, 1, r0 + 1, 20 * BD);
    repeat (3) @(negedge clk);
    chk({name, "_resp"}, resp, r);
    chk({name, "_rdy_pulses"}, rdy_cnt - r0, 1);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int c0, t0, r0;
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles elapsed", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t0, r0, d0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_resp", resp, 8'h00);
    chk("rst_tx", TX, 1);
    chk("rst_cmd_cmplt", cmd_cmplt, 0);
    chk("rst_resp_rdy", resp_rdy, 0);
    chk("rst_resp_tmo", resp_tmo, 0);
    chk("rst_trmt", dut.trmt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Stray byte while idle must be discarded
    send_rx(8'h55);
    repeat (20) @(negedge clk);
    chk("stray_resp", resp, 8'h00);
    chk("stray_rdy_pulses", rdy_cnt, 0);
    chk("stray_busy", busy, 0);

    // SET_PTCH 0x1234 answered with ack
    got_frames.delete();
    c0 = cmplt_cnt;
    t0 = trmt_cnt;
    pulse_snd(8'h02, 16'h1234);
    wait_cnt("t1_cmplt", 0, c0 + 1, 40 * BD);
    repeat (2) @(negedge clk);
    check_frames("t1", 8'h02, 8'h12, 8'h34);
    chk("t1_trmt_count", trmt_cnt - t0, 3);
    chk("t1_cmplt_count", cmplt_cnt - c0, 1);
    chk("t1_busy_waiting", busy, 1);
    chk("t1_resp_before_ack", resp, 8'h00);
    reply_and_check("t1", 8'hA5);

    // snd_cmd while busy is dropped and the shadow holds
    got_frames.delete();
    c0 = cmplt_cnt;
    t0 = trmt_cnt;
    d0 = dec_cnt;
    pulse_snd(8'h08, 16'hC3A0);
    wait_cnt("t2_first_frame", 3, d0 + 1, 15 * BD);
    pulse_snd(8'h05, 16'hFFFF);
    wait_cnt("t2_cmplt", 0, c0 + 1, 40 * BD);
    repeat (2) @(negedge clk);
    check_frames("t2", 8'h08, 8'hC3, 8'hA0);
    chk("t2_trmt_count", trmt_cnt - t0, 3);
    chk("t2_cmplt_count", cmplt_cnt - c0, 1);
    reply_and_check("t2", 8'hA5);

    // Reset during the second frame aborts the command
    got_frames.delete();
    d0 = dec_cnt;
    pulse_snd(8'h03, 16'hABCD);
    wait_cnt("t3_first_frame", 3, d0 + 1, 15 * BD);
    repeat (3 * BD) @(negedge clk);
    chk("t3_in_second_frame", dut.state, 3'd2);
    rst_epoch++;
    rst_n = 1'b0;
    #1;
    chk("t3_rst_busy", busy, 0);
    chk("t3_rst_tx", TX, 1);
    chk("t3_rst_cmplt", cmd_cmplt, 0);
    chk("t3_rst_resp", resp, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c0 = cmplt_cnt;
    r0 = rdy_cnt;
    repeat (40 * BD) @(negedge clk);
    chk("t3_no_cmplt_after_rst", cmplt_cnt - c0, 0);
    chk("t3_no_rdy_after_rst", rdy_cnt - r0, 0);
    got_frames.delete();
    t0 = trmt_cnt;
    pulse_snd(8'h06, 16'h0000);
    wait_cnt("t3_cmplt", 0, c0 + 1, 40 * BD);
    repeat (2) @(negedge clk);
    check_frames("t3", 8'h06, 8'h00, 8'h00);
    chk("t3_trmt_count", trmt_cnt - t0, 3);
    reply_and_check("t3", 8'hA5);

    // No reply
    c0 = cmplt_cnt;
    r0 = rdy_cnt;
    pulse_snd(8'h04, 16'h0102);
    wait_cnt("t4_cmplt", 0, c0 + 1, 40 * BD);
`ifdef RESP_TMO_EN
    wait_cnt("t4_tmo", 2, 1, TMO + 200);
    chk("t4_tmo_delay", tmo_cyc - cmplt_cyc, TMO);
    chk("t4_tmo_count", tmo_cnt, 1);
    repeat (2) @(negedge clk);
    chk("t4_resp_cleared", resp, 8'h00);
    chk("t4_busy_after", busy, 0);
    chk("t4_no_rdy", rdy_cnt - r0, 0);
`else
    repeat (1200) @(negedge clk);
    chk("t4_still_busy", busy, 1);
    chk("t4_no_tmo", tmo_cnt, 0);
    chk("t4_resp_held", resp, 8'hA5);
    reply_and_check("t4", 8'h3C);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
